mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Request/response front-end that sits directly upstream of the 64-word synchronous data memory and is the only master driving it. It accepts one CPU load/store request at a time over a valid/ready handshake and sequences the memory's single-cycle read/write strobes. It registers the memory's one-cycle-latency read data and returns it over a valid/ready response channel. Requests to addresses outside the populated depth are rejected with an error response and never reach the memory.

Parameters:
ADDR_W, 11, address width on both the CPU side and the memory side
DATA_W, 16, data word width
DEPTH, 64, number of populated memory words; valid addresses are 0..DEPTH-1

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
resp_valid  out  1  response present (high only in RESP)
resp_ready  in  1  CPU consumes response
resp_rdata  out  DATA_W  load data; holds last captured value otherwise
resp_err  out  1  qualifies resp_valid: address out of range
mem_address  out  ADDR_W  to memory address
mem_dataIn  out  DATA_W  to memory dataIn
mem_read  out  1  to memory read strobe
mem_write  out  1  to memory write strobe
mem_dataOut  in  DATA_W  from memory dataOut, valid the cycle after the edge that sampled mem_read

Behaviour:
- Clocking: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE.
  - req_ready = 1 (combinational from state).
  - resp_valid = 0, resp_err = 0.
  - resp_rdata = 0, mem_address = 0, mem_dataIn = 0.
  - mem_read = 0, mem_write = 0.
- Register rules:
  - All mem_* outputs are registered.
  - req_ready and resp_valid are decoded from state.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - On req_valid with an in-range address (req_addr < DEPTH): latch the address into mem_address and the data into mem_dataIn.
  - In the same transfer, set mem_read = !req_write and mem_write = req_write, then go to ISSUE.
  - On req_valid with an out-of-range address (req_addr >= DEPTH): set resp_err = 1 and go to RESP. No memory strobe is issued.
- ISSUE:
  - Exactly one strobe is high for exactly one cycle; the memory acts at the closing edge.
  - At that edge, clear both strobes.
  - Read: go to CAPTURE.
  - Write: set resp_err = 0 and go to RESP.
- CAPTURE:
  - At the closing edge, resp_rdata <= mem_dataOut and resp_err <= 0, then go to RESP.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err are held stable while resp_valid is high.
  - On resp_ready, go to IDLE. Otherwise stay in RESP; no new request is accepted.
- Latency, counted in rising edges after the acceptance edge E0:
  - Load: mem_read is high between E0 and E1; resp_valid is first high after E2.
  - Store: mem_write is high between E0 and E1; resp_valid is first high after E1.
  - Error: resp_valid is first high after E0.
  - With resp_ready tied high, throughput is one load per 4 cycles and one store per 3 cycles.
- Store responses leave resp_rdata unchanged. Error responses also leave resp_rdata unchanged.
- Strobe exclusivity: mem_read and mem_write are never high together. This matters because the memory gives read priority and would silently drop the write.
- The address range check uses an unsigned comparison at full ADDR_W width. Addresses that are in range are passed to the memory unmodified.
- Reset mid-operation: reset in any state forces IDLE and clears the strobes on that edge. Any pending response is discarded and the memory action is not retried.
- Request inputs are sampled only at the acceptance edge. Changes to them afterwards are ignored.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum values IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2, RESP=2'd3;
  - the ADDR_W, DATA_W and DEPTH defaults, shared with the memory block.
- A single flat module; no sub-module is warranted.

Test Plan:
- Load from address 10 against the memory's initial contents, resp_ready high -> mem_read high for one cycle with mem_address = 10; resp_valid after E2 with resp_rdata = 0x0009 and resp_err = 0.
- Store 0xBEEF to address 12, then load address 12 -> mem_write pulse with mem_dataIn = 0xBEEF; store response has resp_err = 0 and resp_rdata unchanged; load returns 0xBEEF.
- Load address 11 with resp_ready held low for 5 cycles -> resp_valid held with resp_rdata = 0xFFF4 stable; req_ready = 0 throughout; IDLE is entered on the cycle after resp_ready rises.
- Load address 64 and store to address 0x7FF -> resp_err = 1 on the first cycle after acceptance; mem_read and mem_write never assert; addresses 10 and 11 still read back 0x0009 and 0xFFF4.
- Assert reset while in ISSUE on a store to address 13 -> strobes low next cycle; state IDLE; resp_valid = 0; req_ready = 1 after reset deasserts.
- Back-to-back store then load with req_valid held high -> a checker confirms mem_read and mem_write are never both high and each strobe lasts exactly one cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory and its access front-end.
// The memory block reuses the geometry defaults defined here.
package mem_pkg;

  localparam int MEM_ADDR_W = 11;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front-end for the synchronous data memory.
// Sequences one-cycle memory strobes and returns registered responses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataOut
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  state_t state;
  logic   in_range;

  assign in_range   = {1'b0, req_addr} < LIMIT;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_address <= '0;
      mem_dataIn  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (in_range) begin
              mem_address <= req_addr;
              mem_dataIn  <= req_wdata;
              mem_read    <= !req_write;
              mem_write   <= req_write;
              state       <= ISSUE;
            end else begin
              resp_err <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ISSUE: begin
          // The memory acts on the strobe at this edge; the strobe still tells load from store.
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (mem_read) begin
            state <= CAPTURE;
          end else begin
            resp_err <= 1'b0;
            state    <= RESP;
          end
        end
        CAPTURE: begin
          resp_rdata <= mem_dataOut;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
